// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
// Round-robin arbiter that shares one downstream valid/ready stream between
// NUM_REQ_P upstream requesters. A grant is held for up to BURST_P handshaken
// beats, then priority rotates past the owner. Data and handshake pass through
// combinationally; only the arbitration state (state, owner, pointer, beat
// counter) is registered.
//
// Configuration macro: RR_ARB_BURST_LOCK_EN
//   defined   : burst-locked grants of up to BURST_P beats.
//   undefined : every handshake ends the grant (BURST_P treated as 1, no
//               beat counter is built).
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   data_i      requester data, requester k at [k*WIDTH_P +: WIDTH_P]
//   valid_i     per-requester valid
//   ready_o     per-requester ready (only the grantee sees ready_i)
//   data_o      granted data
//   valid_o     downstream valid
//   ready_i     downstream ready
//   grant_id_o  granted requester index, 0 when valid_o is low
//   busy_o      high while a grant is held (OWNED)
module rr_stream_arbiter #(
  parameter int NUM_REQ_P = 4,
  parameter int WIDTH_P   = 8,
  parameter int BURST_P   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0]   data_i,
  input  logic [NUM_REQ_P-1:0]           valid_i,
  output logic [NUM_REQ_P-1:0]           ready_o,
  output logic [WIDTH_P-1:0]             data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(NUM_REQ_P)-1:0]   grant_id_o,
  output logic                           busy_o
);

  localparam int IDW = $clog2(NUM_REQ_P);
`ifdef RR_ARB_BURST_LOCK_EN
  localparam int BURST_EFF = BURST_P;
  localparam int CNT_W     = $clog2(BURST_P) + 1;
`else
  // Any legal BURST_P collapses to single-beat grants.
  localparam int BURST_EFF = (BURST_P > 0) ? 1 : 0;
`endif

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  ptr_q,   ptr_d;
`ifdef RR_ARB_BURST_LOCK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [IDW-1:0]  pick;
  logic            any_vld;
  logic [IDW-1:0]  g;
  logic            has_g;
  logic            g_vld;
  logic            hs;

  // (base + off) mod NUM_REQ_P, valid for off < NUM_REQ_P; handles
  // non-power-of-two requester counts.
  function automatic logic [IDW-1:0] idx_add(input logic [IDW-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ_P) s = s - NUM_REQ_P;
    return IDW'(s);
  endfunction

  // Rotating priority search. Walking from lowest to highest priority lets
  // the last hit win without needing an early exit.
  always_comb begin
    pick    = '0;
    any_vld = 1'b0;
    for (int i = NUM_REQ_P - 1; i >= 0; i--) begin
      if (valid_i[idx_add(ptr_q, i)]) begin
        pick    = idx_add(ptr_q, i);
        any_vld = 1'b1;
      end
    end
  end

  assign g     = (state_q == OWNED) ? owner_q : pick;
  assign has_g = (state_q == OWNED) || any_vld;

  // Combinational steering of data/valid/ready through the grantee. Reset
  // forces all handshake outputs low regardless of requester activity.
  always_comb begin
    g_vld   = 1'b0;
    data_o  = '0;
    ready_o = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (g == IDW'(k)) begin
        g_vld      = valid_i[k];
        data_o     = data_i[k*WIDTH_P +: WIDTH_P];
        ready_o[k] = ready_i & has_g & ~rst_i;
      end
    end
    valid_o    = g_vld & has_g & ~rst_i;
    grant_id_o = valid_o ? g : '0;
  end

  assign hs     = valid_o & ready_i;
  assign busy_o = (state_q == OWNED) & ~rst_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef RR_ARB_BURST_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          if (hs && (BURST_EFF == 1)) begin
            ptr_d = idx_add(pick, 1);
          end else begin
            // Entered even without a handshake so a stalled offer keeps
            // its grant (stable data_o/grant_id_o under backpressure).
            state_d = OWNED;
            owner_d = pick;
`ifdef RR_ARB_BURST_LOCK_EN
            cnt_d   = hs ? CNT_W'(1) : '0;
`endif
          end
        end
      end
      OWNED: begin
        if (!valid_i[owner_q]) begin
          // Owner went quiet: release, costing one bubble cycle.
          state_d = IDLE;
          ptr_d   = idx_add(owner_q, 1);
        end else if (hs) begin
`ifdef RR_ARB_BURST_LOCK_EN
          if (cnt_q == CNT_W'(BURST_P - 1)) begin
            state_d = IDLE;
            ptr_d   = idx_add(owner_q, 1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          state_d = IDLE;
          ptr_d   = idx_add(owner_q, 1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef RR_ARB_BURST_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_BURST_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
module tb_rr_stream_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;
`ifdef RR_ARB_BURST_LOCK_EN
  localparam int EFF_B = B;
`else
  localparam int EFF_B = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   valid_i;
  logic [N-1:0]   ready_o;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           ready_i;
  logic [1:0]     grant_id_o;
  logic           busy_o;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.NUM_REQ_P(N), .WIDTH_P(W), .BURST_P(B)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a grant is a lease held by one requester, counted in
  // accepted beats; -1 means nobody holds a lease.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  // Values sampled in the most recent cycle, for the hand-written sequences.
  logic [1:0]   s_gid;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic [N-1:0] s_ready;
  logic         s_busy;
  int           s_hs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who would be granted this cycle according to the rotation rules.
  task automatic m_eval(input logic [N-1:0] v, output int g, output bit has);
    has = 1'b0;
    g   = 0;
    if (m_owner >= 0) begin
      g   = m_owner;
      has = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!has && v[k]) begin
          g   = k;
          has = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model at posedge.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic rdy,
                       input logic [N*W-1:0] d);
    int g, eg;
    bit has, ev, eb, hs;
    logic [N-1:0] er;
    rst_i   = r;
    valid_i = v;
    ready_i = rdy;
    data_i  = d;
    #2;
    m_eval(v, g, has);
    er = '0;
    if (r) begin
      ev = 0; eg = 0; eb = 0;
    end else begin
      ev = has && v[g];
      if (has) er[g] = rdy;
      eg = ev ? g : 0;
      eb = (m_owner >= 0);
    end
    chk("valid_o", 32'(valid_o), 32'(ev));
    chk("ready_o", 32'(ready_o), 32'(er));
    chk("grant_id_o", 32'(grant_id_o), 32'(eg));
    chk("busy_o", 32'(busy_o), 32'(eb));
    if (ev) chk("data_o", 32'(data_o), 32'(d[g*W +: W]));
    s_gid   = grant_id_o;
    s_valid = valid_o;
    s_data  = data_o;
    s_ready = ready_o;
    s_busy  = busy_o;
    s_hs    = (valid_o && rdy) ? 1 : 0;
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_beats = 0;
    end else if (has) begin
      hs = v[g] && rdy;
      if (m_owner >= 0 && !v[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_beats = 0;
      end else if (hs) begin
        m_beats++;
        if (m_beats == EFF_B) begin
          m_owner = -1; m_ptr = (g + 1) % N; m_beats = 0;
        end else begin
          m_owner = g;
        end
      end else begin
        m_owner = g;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic [1:0]   egid;
    logic         ev;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [N-1:0] v_prev;
    int beats;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{v: 4'hF, rdy: 1'b1, egid: 2'((i / EFF_B) % N), ev: 1'b1};

    rst_i = 1'b1; valid_i = '0; ready_i = 1'b0; data_i = '0;
    @(negedge clk);

    // Reset held two cycles with everyone requesting.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'hF, 1'b1, 32'h44332211);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
    end

    // Full load table: 16 beats in 16 cycles.
    beats = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].rdy, $urandom);
      chk("tbl_gid", 32'(s_gid), 32'(tbl[i].egid));
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].ev));
      beats += s_hs;
    end
    chk("tbl_beats", beats, 16);

    // Stall: req2 offers A5 under backpressure, req0 joins late.
    cycle(1'b1, 4'h0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, (i == 0) ? 4'b0100 : 4'b0101, 1'b0, 32'h11A52233);
      chk("stall_gid", 32'(s_gid), 32'd2);
      chk("stall_data", 32'(s_data), 32'hA5);
    end
    chk("stall_busy", 32'(s_busy), 32'd1);
    for (int i = 0; i < EFF_B; i++) begin
      cycle(1'b0, 4'b0101, 1'b1, 32'h11A52233);
      chk("stall_drain_gid", 32'(s_gid), 32'd2);
    end
    cycle(1'b0, 4'b0101, 1'b1, 32'h11A52233);
    chk("stall_next_gid", 32'(s_gid), 32'd0);

    // Early release: req1 sends two beats then drops valid.
    cycle(1'b1, 4'h0, 1'b0, '0);
    cycle(1'b0, 4'b0110, 1'b1, $urandom);
    chk("early_first_gid", 32'(s_gid), 32'd1);
    cycle(1'b0, 4'b0110, 1'b1, $urandom);
    cycle(1'b0, 4'b0100, 1'b1, $urandom);
`ifdef RR_ARB_BURST_LOCK_EN
    chk("early_bubble", 32'(s_valid), 32'd0);
`endif
    cycle(1'b0, 4'b0100, 1'b1, $urandom);
    chk("early_then_gid", 32'(s_gid), 32'd2);

    // Wrap: move the pointer to 3 via req2, then req3 and req0 compete.
    cycle(1'b1, 4'h0, 1'b0, '0);
    for (int i = 0; i < EFF_B; i++) cycle(1'b0, 4'b0100, 1'b1, $urandom);
    for (int i = 0; i < EFF_B; i++) begin
      cycle(1'b0, 4'b1001, 1'b1, $urandom);
      chk("wrap_gid3", 32'(s_gid), 32'd3);
    end
    cycle(1'b0, 4'b1001, 1'b1, $urandom);
    chk("wrap_gid0", 32'(s_gid), 32'd0);
    chk("wrap_valid", 32'(s_valid), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    v_prev = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? N'($urandom) : v_prev;
      v_prev = v;
      cycle(($urandom_range(0, 199) == 0), v, ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
